issue_pipe: RTL
===============

# issue_pipe

Two-lane issue-to-execute pipeline that sits directly downstream of the two-lane issue queue. Each cycle it takes up to two granted instructions (lane 1 and lane 2), registers them into a register-read stage, and tracks long-latency ops in a per-lane delay line. It produces the four-slot destination-tag wakeup broadcast that the issue queue consumes as its wakeup input. Both stages are squashed on a branch kill.

## Interface
- WIDTH_REG, 5, register/tag index width; tag 0 means no wakeup.
- WIDTH_TAG, 5, ROB tag width.
- WIDTH_BRM, 3, branch mask width.
- LONG_LAT, 3, long-op wakeup latency in cycles (>= 2).
- WIDTH_O, 7 + WIDTH_BRM + WIDTH_TAG + 2 + 3*WIDTH_REG, instruction word width.
- Instruction field layout, MSB to LSB: op[6:0], brmask, tag, bank[1:0], rd, rs1, rs2.
  - op[6] = 1 marks a long-latency op.

Ports:
- i_clk  in  1  clock. One clock, all state on the rising edge.
- i_rst  in  1  reset. Synchronous, active-high.
- i_inst1, i_inst2  in  WIDTH_O  issued instruction from the queue, lanes 1 and 2.
- i_ready1, i_ready2  in  1  lane holds a valid issued instruction this cycle.
- i_BrKill  in  WIDTH_BRM+1  {enKill, BranchMask}.
- o_inst1, o_inst2  out  WIDTH_O  register-read stage contents.
- o_valid1, o_valid2  out  1  register-read stage valid.
- o_wdest4x  out  4*WIDTH_REG  wakeup broadcast, four slots.
  - Slot k occupies bits [k*WIDTH_REG +: WIDTH_REG].
  - Slots 0/1: short-op rd for lanes 1/2.
  - Slots 2/3: long-op rd for lanes 1/2.
- o_inflight  out  4  count of valid long ops in both delay lines.

## Operation
- Kill match for an entry: i_BrKill[WIDTH_BRM] & |(brmask & i_BrKill[WIDTH_BRM-1:0]).
- Kill applies in the same cycle to:
  - incoming instructions, which are not captured as valid;
  - register-read entries;
  - every delay-line entry.
- A killed entry's valid is cleared at the next edge. Its data may stay stale.
- Register-read stage, per lane:
  - valid <= i_readyN & ~killmatch(i_instN);
  - inst <= i_instN whenever i_readyN, otherwise held.
- Short wakeup: slot N-1 = rd of register-read lane N when valid & ~op[6] & ~killmatch (current cycle). Otherwise 0.
- Long delay line, per lane:
  - LONG_LAT-1 entries of {valid, brmask, rd}.
  - Entry 0 is loaded from the register-read stage when valid & op[6] & ~killmatch.
  - The line shifts every cycle.
- Long wakeup: slot 2/3 = rd of the last delay entry when valid & ~killmatch. Otherwise 0.
- The line advances unconditionally. There is no stall input and no structural hazard; the line is fully pipelined.
- o_inflight is registered. Next value = number of delay-line entries valid after this cycle's shift and kill.
  - Maximum 2*(LONG_LAT-1).
  - Width 4 supports LONG_LAT <= 8.
- rd = 0 is carried through but always broadcasts 0. That is harmless.

## Timing
- Instruction presented with i_ready at edge T:
  - o_valid/o_inst visible in cycle T+1.
  - Short wakeup in cycle T+1.
  - Long wakeup in cycle T+LONG_LAT (default T+3).
- Both lanes are independent and may issue, wake, and kill in the same cycle.
- On simultaneous kill and shift, kill wins: a matching entry never reaches a wakeup slot.
- A kill with enKill=0 has no effect, whatever the mask.
- Reset, including mid-operation, takes effect at the edge where i_rst=1:
  - all valids and o_inflight go to 0;
  - o_inst1/o_inst2 go to 0;
  - o_wdest4x reads 0 from the next cycle onward.
- Inputs presented during the reset cycle are dropped.

## Test plan
- Reset, then i_ready1=1 with short op rd=7, brmask=0 at T:
  - o_valid1=1 and o_wdest4x slot0=7 at T+1;
  - slot0=0 at T+2.
- Long op (op[6]=1) rd=12 on lane 2 at T:
  - slot3=12 only at T+3;
  - o_inflight=1 during T+2 and T+3, 0 at T+4.
- Both lanes issue long ops every cycle for 4 cycles:
  - o_inflight saturates at 4;
  - slot2/slot3 each show one rd per cycle from T+3.
- Long op with brmask=3'b010 at T, then i_BrKill=4'b1010 at T+2:
  - no slot3 wakeup at T+3;
  - o_inflight drops to 0.
  - The same kill with enKill=0 leaves the wakeup intact.
- Same-cycle kill of an incoming instruction with brmask=3'b001, i_BrKill=4'b1001: o_valid1=0 at T+1 and no wakeup ever.
- Assert i_rst with 2 long ops in flight:
  - all outputs 0 next cycle;
  - no stale long wakeup afterwards.

Source files
------------

// File: rtl/issue_pipe.sv
// Two-lane register-read stage with a per-lane long-op delay line.
// Produces the four-slot destination-tag wakeup broadcast consumed by the issue queue.
module issue_pipe #(
    parameter  int unsigned WIDTH_REG = 5,
    parameter  int unsigned WIDTH_TAG = 5,
    parameter  int unsigned WIDTH_BRM = 3,
    parameter  int unsigned LONG_LAT  = 3,
    localparam int unsigned WIDTH_O   = 7 + WIDTH_BRM + WIDTH_TAG + 2 + 3 * WIDTH_REG
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [WIDTH_O-1:0]     i_inst1,
    input  logic [WIDTH_O-1:0]     i_inst2,
    input  logic                   i_ready1,
    input  logic                   i_ready2,
    input  logic [WIDTH_BRM:0]     i_BrKill,
    output logic [WIDTH_O-1:0]     o_inst1,
    output logic [WIDTH_O-1:0]     o_inst2,
    output logic                   o_valid1,
    output logic                   o_valid2,
    output logic [4*WIDTH_REG-1:0] o_wdest4x,
    output logic [3:0]             o_inflight
);

    localparam int unsigned DEPTH    = LONG_LAT - 1;
    localparam int unsigned RD_LSB   = 2 * WIDTH_REG;
    localparam int unsigned BRM_LSB  = 3 * WIDTH_REG + 2 + WIDTH_TAG;
    localparam int unsigned LONG_BIT = WIDTH_O - 1;
    localparam int unsigned CNT_W    = 4;

    logic [WIDTH_O-1:0]   in_inst    [2];
    logic                 in_ready   [2];
    logic [WIDTH_O-1:0]   rr_inst_q  [2];
    logic [WIDTH_O-1:0]   rr_inst_d  [2];
    logic                 rr_valid_q [2];
    logic                 rr_valid_d [2];
    logic                 rr_live    [2];
    logic                 dl_valid_q [2][DEPTH];
    logic                 dl_valid_d [2][DEPTH];
    logic [WIDTH_BRM-1:0] dl_brm_q   [2][DEPTH];
    logic [WIDTH_BRM-1:0] dl_brm_d   [2][DEPTH];
    logic [WIDTH_REG-1:0] dl_rd_q    [2][DEPTH];
    logic [WIDTH_REG-1:0] dl_rd_d    [2][DEPTH];
    logic [WIDTH_REG-1:0] wdest      [4];
    logic [CNT_W-1:0]     inflight_q;
    logic [CNT_W-1:0]     inflight_d;

    function automatic logic kill_match(input logic [WIDTH_BRM-1:0] brm,
                                        input logic [WIDTH_BRM:0]   brkill);
        return brkill[WIDTH_BRM] & (|(brm & brkill[WIDTH_BRM-1:0]));
    endfunction

    assign in_inst[0]  = i_inst1;
    assign in_inst[1]  = i_inst2;
    assign in_ready[0] = i_ready1;
    assign in_ready[1] = i_ready2;

    // Next-state for both lanes; kill masks the load, the shift and the wakeup slots.
    always_comb begin
        inflight_d = '0;
        for (int l = 0; l < 2; l++) begin
            rr_valid_d[l] = in_ready[l] & ~kill_match(in_inst[l][BRM_LSB +: WIDTH_BRM], i_BrKill);
            rr_inst_d[l]  = in_ready[l] ? in_inst[l] : rr_inst_q[l];
            rr_live[l]    = rr_valid_q[l] & ~kill_match(rr_inst_q[l][BRM_LSB +: WIDTH_BRM], i_BrKill);
            wdest[l]      = (rr_live[l] & ~rr_inst_q[l][LONG_BIT])
                          ? rr_inst_q[l][RD_LSB +: WIDTH_REG] : '0;

            dl_valid_d[l][0] = rr_live[l] & rr_inst_q[l][LONG_BIT];
            dl_brm_d[l][0]   = rr_inst_q[l][BRM_LSB +: WIDTH_BRM];
            dl_rd_d[l][0]    = rr_inst_q[l][RD_LSB +: WIDTH_REG];
            for (int k = 1; k < int'(DEPTH); k++) begin
                dl_valid_d[l][k] = dl_valid_q[l][k-1] & ~kill_match(dl_brm_q[l][k-1], i_BrKill);
                dl_brm_d[l][k]   = dl_brm_q[l][k-1];
                dl_rd_d[l][k]    = dl_rd_q[l][k-1];
            end

            wdest[2+l] = (dl_valid_q[l][DEPTH-1] & ~kill_match(dl_brm_q[l][DEPTH-1], i_BrKill))
                       ? dl_rd_q[l][DEPTH-1] : '0;

            for (int k = 0; k < int'(DEPTH); k++) begin
                inflight_d = inflight_d + CNT_W'(dl_valid_d[l][k]);
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight_q <= '0;
            for (int l = 0; l < 2; l++) begin
                rr_valid_q[l] <= 1'b0;
                rr_inst_q[l]  <= '0;
                for (int k = 0; k < int'(DEPTH); k++) begin
                    dl_valid_q[l][k] <= 1'b0;
                    dl_brm_q[l][k]   <= '0;
                    dl_rd_q[l][k]    <= '0;
                end
            end
        end else begin
            inflight_q <= inflight_d;
            rr_valid_q <= rr_valid_d;
            rr_inst_q  <= rr_inst_d;
            dl_valid_q <= dl_valid_d;
            dl_brm_q   <= dl_brm_d;
            dl_rd_q    <= dl_rd_d;
        end
    end

    assign o_inst1    = rr_inst_q[0];
    assign o_inst2    = rr_inst_q[1];
    assign o_valid1   = rr_valid_q[0];
    assign o_valid2   = rr_valid_q[1];
    assign o_inflight = inflight_q;
    assign o_wdest4x  = {wdest[3], wdest[2], wdest[1], wdest[0]};

endmodule
